// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte transmitter between NUM_REQ byte sources.
// Latency: valid sampled in IDLE -> req_ready next cycle -> tx_start the cycle after.
// Backpressure: a source waits with valid high; only the grant owner sees req_ready.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic [CNT_W-1:0]     sent_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BST_W = $clog2(MAX_BURST + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [BST_W-1:0]   burst_cnt;
    logic               last_q;

    // owner-side views of the request bus
    logic [PTR_W-1:0]   owner;
    logic               owner_vld;
    logic [7:0]         owner_data;
    logic               owner_last;
    logic [PTR_W-1:0]   ptr_rel;

    // arbitration signals
    logic [2*NUM_REQ-1:0] vld_dbl;
    logic [NUM_REQ-1:0]   vld_rot;
    logic [PTR_W-1:0]     win_off;
    logic [PTR_W:0]       win_sum;
    logic [PTR_W-1:0]     winner;
    logic                 found;
    logic                 any_vld;
    logic                 burst_full;

    // Decode the current owner from the one-hot grant and pick out its request lane.
    always_comb begin
        owner      = '0;
        owner_vld  = 1'b0;
        owner_data = 8'h00;
        owner_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                owner      = PTR_W'(i);
                owner_vld  = req_valid[i];
                owner_data = req_data[8*i +: 8];
                owner_last = req_last[i];
            end
        end
        if (owner == PTR_W'(NUM_REQ - 1)) begin
            ptr_rel = '0;
        end else begin
            ptr_rel = owner + PTR_W'(1);
        end
    end

    // Round-robin search: rotate valids so ptr sits at bit 0, take the first set bit,
    // then rotate the offset back into a requester index.
    always_comb begin
        vld_dbl = {req_valid, req_valid} >> ptr;
        vld_rot = vld_dbl[NUM_REQ-1:0];
        win_off = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && vld_rot[i]) begin
                win_off = PTR_W'(i);
                found   = 1'b1;
            end
        end
        win_sum = {1'b0, ptr} + {1'b0, win_off};
        if (win_sum >= (PTR_W+1)'(NUM_REQ)) begin
            win_sum = win_sum - (PTR_W+1)'(NUM_REQ);
        end
        winner = win_sum[PTR_W-1:0];
    end

    assign any_vld    = |req_valid;
    // the byte now completing is the last one this grant may send
    assign burst_full = (burst_cnt == BST_W'(MAX_BURST - 1));

    // Main control FSM: grant ownership, byte capture, uart handshake and release.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= S_IDLE;
            grant     <= '0;
            tx_data   <= 8'h00;
            last_q    <= 1'b0;
            burst_cnt <= '0;
            ptr       <= '0;
            sent_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // a busy transmitter blocks arbitration entirely
                    if (any_vld && tx_done) begin
                        grant     <= NUM_REQ'(1) << winner;
                        burst_cnt <= '0;
                        state     <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (owner_vld) begin
                        tx_data <= owner_data;
                        last_q  <= owner_last;
                        state   <= S_START;
                    end else begin
                        ptr   <= ptr_rel;
                        grant <= '0;
                        state <= S_IDLE;
                    end
                end
                S_START: begin
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!tx_done) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (tx_done) begin
                        sent_cnt  <= sent_cnt + CNT_W'(1);
                        burst_cnt <= burst_cnt + BST_W'(1);
                        // hold the grant only while the message continues and budget remains
                        if (last_q || burst_full || !owner_vld) begin
                            ptr   <= ptr_rel;
                            grant <= '0;
                            state <= S_IDLE;
                        end else begin
                            state <= S_ACCEPT;
                        end
                    end
                end
                default: begin
                    grant <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ready is a pure decode so the source sees it in the same cycle as its valid;
    // it is suppressed while reset is asserted so no byte is taken in that cycle
    assign req_ready = grant & {NUM_REQ{(state == S_ACCEPT) && owner_vld && !PRESET}};
    assign tx_start  = (state == S_START);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: byte-source and uart models plus a transaction reference.
// Inputs are driven 1 time unit after each rising edge, outputs sampled 1 unit later.
// Sources hold valid until ready; the uart model answers each tx_start with a busy pulse.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int MB = 16;
    localparam int CW = 4;

    logic           PCLK = 1'b0;
    logic           PRESET;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [N*8-1:0] req_data;
    logic           busy, tx_start, tx_done;
    logic [7:0]     tx_data;
    logic [CW-1:0]  sent_cnt;

    uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .CNT_W(CW)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .grant(grant), .busy(busy),
        .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .sent_cnt(sent_cnt)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_err    = 0;

    // byte sources: per-requester message buffers {last,data}
    logic [8:0] rbuf [N][64];
    int  rhead [N];
    int  rtail [N];
    int  gap   [N];
    bit  retract [N];
    int  gap_pct;
    bit  rst_req;

    // uart model
    bit force_busy;
    bit u_active;
    int u_delay, u_busy;

    // what the DUT saw at the edge just passed
    logic [N-1:0]   pv_valid, pv_last, pv_ready;
    logic [N*8-1:0] pv_data;
    logic           pv_done, pv_rst, pv_start;

    // reference model of the arbitration contract
    int         m_own, m_ptr, m_burst, m_sent;
    bit         m_acc, m_st, m_fl, m_low, m_lastb;
    logic [7:0] m_data;

    // observed transmissions
    int         log_own [$];
    logic [7:0] log_dat [$];

    function automatic bit bit_at(input logic [N-1:0] v, input int i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_msg(input int i, input int len, input int base, input bit rnd);
        if (rhead[i] == rtail[i]) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
        for (int b = 0; b < len; b++) begin
            rbuf[i][rtail[i]] = {(b == len - 1), rnd ? 8'($urandom) : 8'(base + b)};
            rtail[i]++;
        end
    endtask

    task automatic release_owner();
        m_ptr = (m_own + 1) % N;
        m_own = -1;
    endtask

    // Reference: what the arbiter must have done at the edge just passed.
    task automatic model_edge();
        if (pv_rst) begin
            m_own = -1; m_ptr = 0; m_burst = 0; m_sent = 0;
            m_acc = 0; m_st = 0; m_fl = 0; m_low = 0; m_lastb = 0;
            m_data = 8'h00;
        end else if (m_own < 0) begin
            if (pv_valid != '0 && pv_done) begin
                for (int k = 0; k < N; k++)
                    if (m_own < 0 && bit_at(pv_valid, (m_ptr + k) % N)) m_own = (m_ptr + k) % N;
                m_burst = 0;
                m_acc   = 1;
            end
        end else if (m_acc) begin
            m_acc = 0;
            if (bit_at(pv_valid, m_own)) begin
                m_data  = 8'(pv_data >> (8 * m_own));
                m_lastb = bit_at(pv_last, m_own);
                m_st    = 1;
            end else begin
                release_owner();
            end
        end else if (m_st) begin
            m_st = 0; m_fl = 1; m_low = 0;
        end else if (m_fl) begin
            if (!m_low) begin
                if (!pv_done) m_low = 1;
            end else if (pv_done) begin
                m_fl = 0;
                m_sent++;
                m_burst++;
                if (m_lastb || m_burst == MB || !bit_at(pv_valid, m_own)) release_owner();
                else m_acc = 1;
            end
        end
    endtask

    task automatic uart_update();
        if (pv_start) begin
            u_active = 1;
            u_delay  = $urandom_range(2);
            u_busy   = $urandom_range(4, 1);
        end else if (u_active) begin
            if (u_delay > 0) u_delay--;
            else if (u_busy > 0) u_busy--;
            else u_active = 0;
        end
        tx_done = force_busy ? 1'b0 : !(u_active && u_delay == 0 && u_busy > 0);
    endtask

    task automatic drive_inputs();
        PRESET = rst_req;
        for (int i = 0; i < N; i++) begin
            if (rst_req) begin
                rhead[i] = 0; rtail[i] = 0; gap[i] = 0; retract[i] = 0;
            end
            if (retract[i] && bit_at(pv_valid, i) && !bit_at(pv_ready, i) && rhead[i] < rtail[i]) begin
                rhead[i]++;
                retract[i] = 0;
            end
            if (gap[i] > 0) gap[i]--;
            if (rhead[i] < rtail[i] && gap[i] == 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = rbuf[i][rhead[i]][7:0];
                req_last[i]        = rbuf[i][rhead[i]][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i]        = 1'($urandom);
            end
        end
    endtask

    task automatic step();
        logic [N-1:0] exp_g, exp_r;
        @(posedge PCLK);
        #1;
        for (int i = 0; i < N; i++) begin
            if (bit_at(pv_ready, i) && rhead[i] < rtail[i]) begin
                rhead[i]++;
                if (gap_pct > 0 && $urandom_range(99) < gap_pct) gap[i] = $urandom_range(4, 2);
            end
        end
        model_edge();
        uart_update();
        drive_inputs();
        #1;
        exp_g = (m_own >= 0) ? (N'(1) << m_own) : '0;
        exp_r = (m_acc && !PRESET && bit_at(req_valid, m_own)) ? exp_g : '0;
        chk("grant",    32'(grant),     32'(exp_g));
        chk("req_ready", 32'(req_ready), 32'(exp_r));
        chk("tx_start", 32'(tx_start),  32'(m_st));
        chk("tx_data",  32'(tx_data),   32'(m_data));
        chk("busy",     32'(busy),      32'(m_own >= 0));
        chk("sent_cnt", 32'(sent_cnt),  32'(m_sent % (1 << CW)));
        if (tx_start) begin
            int o;
            o = -1;
            for (int i = 0; i < N; i++) if (grant[i]) o = i;
            log_own.push_back(o);
            log_dat.push_back(tx_data);
        end
        pv_valid = req_valid; pv_last = req_last; pv_data = req_data;
        pv_done  = tx_done;   pv_rst  = PRESET;   pv_ready = req_ready;
        pv_start = tx_start;
    endtask

    function automatic bit pending();
        bit p;
        p = (m_own >= 0) || u_active;
        for (int i = 0; i < N; i++) if (rhead[i] < rtail[i]) p = 1;
        return p;
    endfunction

    task automatic run_idle(input int budget);
        int  c;
        bit  timed_out;
        c = 0;
        while (pending() && c < budget) begin
            step();
            c++;
        end
        timed_out = pending();
        chk("drain_timeout", 32'(timed_out), 32'(0));
    endtask

    task automatic do_reset();
        rst_req = 1;
        step();
        step();
        rst_req = 0;
        step();
        log_own.delete();
        log_dat.delete();
    endtask

    initial begin
        int exp2 [6];
        int eo;
        int c;
        logic [7:0] ed;

        exp2 = '{0, 1, 2, 3, 0, 1};
        PRESET = 1'b1; rst_req = 1; tx_done = 1'b1;
        req_valid = '0; req_last = '0; req_data = '0;
        force_busy = 0; u_active = 0; u_delay = 0; u_busy = 0; gap_pct = 0;
        pv_valid = '0; pv_last = '0; pv_data = '0; pv_ready = '0;
        pv_done = 1'b1; pv_rst = 1'b1; pv_start = 1'b0;
        m_own = -1; m_ptr = 0; m_burst = 0; m_sent = 0;
        m_acc = 0; m_st = 0; m_fl = 0; m_low = 0; m_lastb = 0; m_data = 8'h00;
        for (int i = 0; i < N; i++) begin
            rhead[i] = 0; rtail[i] = 0; gap[i] = 0; retract[i] = 0;
        end

        // reset state
        do_reset();
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_busy",  32'(busy),  32'(0));
        chk("rst_cnt",   32'(sent_cnt), 32'(0));
        chk("rst_data",  32'(tx_data),  32'(0));

        // single byte from requester 0
        push_msg(0, 1, 8'h55, 0);
        run_idle(200);
        chk("t1_count", 32'(log_own.size()), 32'(1));
        if (log_own.size() > 0) begin
            chk("t1_owner", 32'(log_own[0]), 32'(0));
            chk("t1_data",  32'(log_dat[0]), 32'(8'h55));
        end
        chk("t1_sent", 32'(sent_cnt), 32'(1));

        // everyone contends with single-byte messages
        do_reset();
        push_msg(0, 1, 8'hA0, 0); push_msg(0, 1, 8'hA0, 0);
        push_msg(1, 1, 8'hA1, 0); push_msg(1, 1, 8'hA1, 0);
        push_msg(2, 1, 8'hA2, 0); push_msg(3, 1, 8'hA3, 0);
        run_idle(400);
        chk("t2_count", 32'(log_own.size()), 32'(6));
        for (int k = 0; k < 6; k++) begin
            if (k < log_own.size()) begin
                chk("t2_owner", 32'(log_own[k]), 32'(exp2[k]));
                chk("t2_data",  32'(log_dat[k]), 32'(8'hA0 + exp2[k]));
            end
        end

        // burst limit splits a 20-byte message around a waiting requester
        do_reset();
        push_msg(2, 20, 8'h20, 0);
        step(); step();
        push_msg(1, 1, 8'h99, 0);
        run_idle(1000);
        chk("t3_count", 32'(log_own.size()), 32'(21));
        for (int k = 0; k < 21; k++) begin
            eo = (k == 16) ? 1 : 2;
            ed = (k < 16) ? 8'(8'h20 + k) : (k == 16) ? 8'h99 : 8'(8'h20 + k - 1);
            if (k < log_own.size()) begin
                chk("t3_owner", 32'(log_own[k]), 32'(eo));
                chk("t3_data",  32'(log_dat[k]), 32'(ed));
            end
        end

        // transmitter busy blocks arbitration
        do_reset();
        force_busy = 1;
        push_msg(1, 1, 8'h41, 0);
        for (int k = 0; k < 6; k++) step();
        chk("t4_grant", 32'(grant), 32'(0));
        chk("t4_ready", 32'(req_ready), 32'(0));
        force_busy = 0;
        run_idle(200);
        chk("t4_count", 32'(log_own.size()), 32'(1));
        if (log_own.size() > 0) chk("t4_owner", 32'(log_own[0]), 32'(1));

        // reset while a byte from requester 2 is in flight
        do_reset();
        push_msg(2, 3, 8'h70, 0);
        c = 0;
        while (!(m_fl && m_low) && c < 200) begin
            step();
            c++;
        end
        chk("t5_reach", 32'(m_fl && m_low), 32'(1));
        rst_req = 1;
        step();
        rst_req = 0;
        step();
        chk("t5_grant", 32'(grant), 32'(0));
        chk("t5_busy",  32'(busy),  32'(0));
        chk("t5_cnt",   32'(sent_cnt), 32'(0));
        chk("t5_data",  32'(tx_data),  32'(0));
        log_own.delete(); log_dat.delete();
        push_msg(3, 1, 8'h33, 0);
        push_msg(0, 1, 8'h30, 0);
        run_idle(400);
        chk("t5_count", 32'(log_own.size()), 32'(2));
        if (log_own.size() > 1) begin
            chk("t5_first",  32'(log_own[0]), 32'(0));
            chk("t5_second", 32'(log_own[1]), 32'(3));
        end

        // valid withdrawn in ACCEPT, then counter wrap
        do_reset();
        retract[0] = 1;
        push_msg(0, 1, 8'hEE, 0);
        for (int k = 0; k < 4; k++) step();
        chk("t6_no_start", 32'(log_own.size()), 32'(0));
        push_msg(0, 1, 8'h10, 0);
        push_msg(1, 1, 8'h11, 0);
        for (int k = 0; k < 15; k++) push_msg($urandom_range(N - 1), 1, 0, 1);
        run_idle(2000);
        chk("t6_count", 32'(log_own.size()), 32'(17));
        if (log_own.size() > 0) chk("t6_ptr_adv", 32'(log_own[0]), 32'(1));
        chk("t6_wrap", 32'(sent_cnt), 32'(1));

        // randomized traffic with gaps, varied lengths and occasional resets
        do_reset();
        gap_pct = 25;
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < N; i++)
                if (rhead[i] == rtail[i] && $urandom_range(99) < 60)
                    push_msg(i, $urandom_range(20, 1), 0, 1);
            c = $urandom_range(100, 20);
            for (int k = 0; k < c; k++) step();
            if ($urandom_range(99) < 8) begin
                rst_req = 1;
                step();
                rst_req = 0;
            end
        end
        run_idle(4000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
